// File: rtl/cycler_seeker_pkg.sv
// Shared definitions for the cycler seeker: state encoding, position width and
// the shortest-path planner for a position that wraps modulo 8.
package cycler_seeker_pkg;

  localparam int POS_W = 3;
  localparam int CNT_W = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef struct packed {
    logic             dir;
    logic [POS_W-1:0] steps;
  } plan_t;

  // A distance of exactly half the ring is resolved upward.
  function automatic plan_t plan_move(input logic [POS_W-1:0] target,
                                      input logic [POS_W-1:0] from);
    logic [POS_W-1:0] d;
    plan_t p;
    d       = target - from;
    p.dir   = (d > 3'd4);
    p.steps = p.dir ? (3'd0 - d) : d;
    return p;
  endfunction

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] cur,
                                                input logic dir);
    return dir ? (cur - 3'd1) : (cur + 3'd1);
  endfunction

endpackage

// File: rtl/cycler_step_timer.sv
// Loadable down-counter timing the high and low phases of each step strobe.
module cycler_step_timer
  import cycler_seeker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cycler_seeker.sv
// Drives an unresettable position cycler along the shortest path to a target,
// keeping a shadow copy of its position and pacing strobes with a step timer.
module cycler_seeker
  import cycler_seeker_pkg::*;
#(
  parameter int STEP_HI = 2,
  parameter int STEP_LO = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [POS_W-1:0] req_target,
  output logic             req_ready,
  input  logic             cal_valid,
  input  logic [POS_W-1:0] cal_pos,
  input  logic             abort,
  output logic             cyc_dir,
  output logic             cyc_nxt,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(STEP_HI - 1);
  localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(STEP_LO - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] steps_q;
  logic             abort_seen;
  logic             dir_q;
  logic             nxt_q;
  logic             busy_q;
  logic             ready_q;
  logic             done_q;
  logic             aborted_q;

  logic             accept;
  logic             in_step;
  logic             enter_hi;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  plan_t            plan;

  // Calibration has priority over a request presented in the same cycle.
  assign req_ready = ready_q & ~cal_valid;
  assign accept    = req_valid & req_ready;
  assign plan      = plan_move(req_target, pos_q);
  assign in_step   = (state == ST_HI) || (state == ST_LO);
  assign enter_hi  = (state_nxt == ST_HI) && (state != ST_HI);

  cycler_step_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = HI_LOAD;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (plan.steps == '0) ? ST_FIN : ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_HI;
        tmr_load  = 1'b1;
      end
      ST_HI: begin
        if (tmr_zero) begin
          state_nxt = ST_LO;
          tmr_load  = 1'b1;
          tmr_val   = LO_LOAD;
        end
      end
      ST_LO: begin
        // An abort in the final low cycle still prevents the next step.
        if (tmr_zero) begin
          if ((steps_q != '0) && !abort_seen && !abort) begin
            state_nxt = ST_HI;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = ST_FIN;
          end
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pos_q      <= '0;
      steps_q    <= '0;
      abort_seen <= 1'b0;
      dir_q      <= 1'b0;
      nxt_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy_q  <= (state_nxt != ST_IDLE);
      ready_q <= (state_nxt == ST_IDLE);
      done_q  <= (state_nxt == ST_FIN);
      nxt_q   <= (state_nxt == ST_HI);

      if (state_nxt == ST_FIN) begin
        aborted_q <= abort_seen | (abort & in_step);
      end else begin
        aborted_q <= 1'b0;
      end

      if (accept) begin
        abort_seen <= 1'b0;
      end else if (in_step && abort) begin
        abort_seen <= 1'b1;
      end

      if (accept) begin
        dir_q   <= plan.dir;
        steps_q <= plan.steps;
      end else if (enter_hi) begin
        steps_q <= steps_q - 1'b1;
      end

      if ((state == ST_IDLE) && cal_valid) begin
        pos_q <= cal_pos;
      end else if (enter_hi) begin
        pos_q <= step_pos(pos_q, dir_q);
      end
    end
  end

  assign cyc_dir = dir_q;
  assign cyc_nxt = nxt_q;
  assign pos     = pos_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_cycler_seeker.sv
// Scoreboard bench for cycler_seeker with a behavioural blind cycler on the
// strobe/direction outputs; a negedge monitor owns every comparison.
module tb_cycler_seeker;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_target;
  logic       req_ready;
  logic       cal_valid;
  logic [2:0] cal_pos;
  logic       abort;
  logic       cyc_dir;
  logic       cyc_nxt;
  logic [2:0] pos;
  logic       busy;
  logic       done;
  logic       aborted;

  always #5 clk = ~clk;

  cycler_seeker #(.STEP_HI(2), .STEP_LO(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .cal_valid  (cal_valid),
    .cal_pos    (cal_pos),
    .abort      (abort),
    .cyc_dir    (cyc_dir),
    .cyc_nxt    (cyc_nxt),
    .pos        (pos),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  typedef struct {
    logic [2:0] pos;
    logic       ab;
    int         n;
    logic       dir;
    int         lat;
    int         base;
    int         acc;
  } done_rec_t;

  typedef struct {
    int         id;
    logic [2:0] pos;
    logic       nxt;
    logic       busy;
    logic       ready;
    logic       done;
  } snap_t;

  done_rec_t  exp_q[$];
  snap_t      snap_q[$];
  logic [2:0] pos_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int tmo_req  = 0;
  int tmo_seen = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  // Blind cycler: no reset, advances on each rising strobe edge.
  logic [2:0] net = 3'd0;
  int         strobe_total = 0;
  logic [2:0] base_pos = 3'd0;
  logic [2:0] cur = 3'd0;

  always @(posedge cyc_nxt) begin
    net <= net + (cyc_dir ? 3'd7 : 3'd1);
    strobe_total <= strobe_total + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at cycle %0d", nm, act, want, cyc);
    end
  endtask

  logic nxt_prev = 1'b0;

  always @(negedge clk) begin
    done_rec_t r;
    snap_t     s;
    logic [2:0] cyc_now;
    logic [2:0] p;
    if (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      chk($sformatf("snap%0d_pos", s.id), pos, s.pos);
      chk($sformatf("snap%0d_nxt", s.id), cyc_nxt, s.nxt);
      chk($sformatf("snap%0d_busy", s.id), busy, s.busy);
      chk($sformatf("snap%0d_ready", s.id), req_ready, s.ready);
      chk($sformatf("snap%0d_done", s.id), done, s.done);
    end
    if (cyc_nxt && !nxt_prev) begin
      if (pos_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        p = pos_q.pop_front();
        chk("strobe_pos", pos, p);
      end
    end
    nxt_prev = cyc_nxt;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        r = exp_q.pop_front();
        cyc_now = base_pos + net;
        chk("done_pos", pos, r.pos);
        chk("done_aborted", aborted, r.ab);
        chk("done_strobes", strobe_total - r.base, r.n);
        chk("done_dir", cyc_dir, r.dir);
        chk("done_latency", cyc - r.acc, r.lat);
        chk("cycler_eq_pos", cyc_now, pos);
      end
    end
    if (tmo_req != tmo_seen) begin
      chk("timeout", tmo_req, tmo_seen);
      tmo_seen = tmo_req;
    end
    if (end_req && !end_ack) begin
      chk("leftover_expectations", exp_q.size() + pos_q.size(), 0);
      end_ack = 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int id, input logic [2:0] p, input logic n,
                      input logic b, input logic r, input logic d);
    snap_t s;
    s.id = id; s.pos = p; s.nxt = n; s.busy = b; s.ready = r; s.done = d;
    snap_q.push_back(s);
  endtask

  // Physically place the cycler at v and tell the seeker about it.
  task automatic cal_to(input logic [2:0] v, input int id);
    base_pos  = v - net;
    cal_valid = 1'b1;
    cal_pos   = v;
    tick;
    cal_valid = 1'b0;
    cur = v;
    snap(id, v, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
  endtask

  task automatic do_move(input logic [2:0] tgt, input logic [2:0] exp_pos,
                         input logic exp_ab, input int exp_n, input logic exp_dir,
                         input int exp_lat, input int abort_at);
    done_rec_t r;
    int guard;
    int start_done;
    logic ab_sent;
    guard = 0;
    while (!req_ready && guard < 100) begin tick; guard++; end
    if (guard >= 100) begin tmo_req++; return; end
    r.pos = exp_pos; r.ab = exp_ab; r.n = exp_n; r.dir = exp_dir;
    r.lat = exp_lat; r.base = strobe_total; r.acc = cyc;
    exp_q.push_back(r);
    start_done = done_cnt;
    req_valid  = 1'b1;
    req_target = tgt;
    tick;
    req_valid = 1'b0;
    guard = 0;
    ab_sent = 1'b0;
    while (done_cnt == start_done && guard < 300) begin
      if (abort_at != 0 && !ab_sent && cyc_nxt && (strobe_total - r.base) == abort_at) begin
        abort = 1'b1;
        ab_sent = 1'b1;
      end else begin
        abort = 1'b0;
      end
      tick;
      guard++;
    end
    abort = 1'b0;
    if (guard >= 300) tmo_req++;
    cur = exp_pos;
    tick;
  endtask

  initial begin
    logic [2:0] t;
    logic [2:0] d;
    logic [2:0] p;
    logic       dr;
    int         n;
    int         guard;

    rst = 1'b1; req_valid = 1'b0; req_target = 3'd0;
    cal_valid = 1'b0; cal_pos = 3'd0; abort = 1'b0;
    tick; tick; tick;
    snap(1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    rst = 1'b0;
    tick;

    // 0 -> 3 upward
    pos_q.push_back(3'd1); pos_q.push_back(3'd2); pos_q.push_back(3'd3);
    do_move(3'd3, 3'd3, 1'b0, 3, 1'b0, 14, 0);

    // 1 -> 6 downward through the wrap
    cal_to(3'd1, 2);
    pos_q.push_back(3'd0); pos_q.push_back(3'd7); pos_q.push_back(3'd6);
    do_move(3'd6, 3'd6, 1'b0, 3, 1'b1, 14, 0);

    // 2 -> 6 is a tie and goes up; then a zero-length move
    cal_to(3'd2, 3);
    pos_q.push_back(3'd3); pos_q.push_back(3'd4);
    pos_q.push_back(3'd5); pos_q.push_back(3'd6);
    do_move(3'd6, 3'd6, 1'b0, 4, 1'b0, 18, 0);
    do_move(3'd6, 3'd6, 1'b0, 0, 1'b0, 1, 0);

    // 0 -> 4 aborted during the second high phase
    cal_to(3'd0, 4);
    pos_q.push_back(3'd1); pos_q.push_back(3'd2);
    do_move(3'd4, 3'd2, 1'b1, 2, 1'b0, 10, 2);

    // calibration beats a simultaneous request
    base_pos  = 3'd5 - net;
    cal_valid = 1'b1; cal_pos = 3'd5;
    req_valid = 1'b1; req_target = 3'd0;
    snap(5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    cal_valid = 1'b0; req_valid = 1'b0;
    cur = 3'd5;
    snap(6, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;

    // reset in the middle of a high phase
    pos_q.push_back(3'd6);
    req_valid = 1'b1; req_target = 3'd7;
    tick;
    req_valid = 1'b0;
    guard = 0;
    while (!cyc_nxt && guard < 50) begin tick; guard++; end
    if (guard >= 50) tmo_req++;
    rst = 1'b1;
    tick;
    snap(7, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    rst = 1'b0;
    tick;
    cal_to(3'(base_pos + net), 8);

    // random targets checked against the blind cycler
    for (int i = 0; i < 20; i++) begin
      t  = 3'($urandom_range(0, 7));
      d  = t - cur;
      dr = (d > 3'd4);
      n  = dr ? 8 - int'(d) : int'(d);
      p  = cur;
      for (int k = 0; k < n; k++) begin
        p = dr ? p - 3'd1 : p + 3'd1;
        pos_q.push_back(p);
      end
      do_move(t, t, 1'b0, n, dr, (n == 0) ? 1 : 2 + 4 * n, 0);
    end

    tick;
    end_req = 1'b1;
    guard = 0;
    while (!end_ack && guard < 10) begin tick; guard++; end
    if (!end_ack) begin
      $display("FAIL end_handshake got=0 want=1");
      bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
